bram_stream_reader: RTL and testbench
=====================================

# bram_stream_reader

Read-side controller for the single-port `bram` block. On a `start` command it walks a contiguous, wrap-around address range and issues one read per cycle. It absorbs the BRAM's one-cycle registered read latency and delivers the words as a valid/ready stream. It sits between matrix storage and the downstream compute/output logic, and tolerates arbitrary backpressure without losing or duplicating words.

## Interface
- `DATA_WIDTH`, 32, BRAM word width.
- `DEPTH`, 128, BRAM depth in words; need not be a power of two.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, BRAM address width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  command strobe; sampled only while idle.
- `base_addr`  in  ADDR_WIDTH  first word address, sampled with `start`.
- `length`  in  ADDR_WIDTH+1  word count, 0..DEPTH, sampled with `start`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `bram_addr`  out  ADDR_WIDTH  to BRAM `addr`; the BRAM `wr_en` is held 0 by the parent while `busy`.
- `bram_dout`  in  DATA_WIDTH  from BRAM `dout`, valid one cycle after `bram_addr`.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  final beat marker; present only with `BRAM_RD_LAST_EN`.

## Operation
- States:
  - IDLE, RUN.
  - IDLE -> RUN on `start` with effective length > 0.
  - RUN -> IDLE when the final beat handshakes (`m_valid && m_ready`).
- Effective length: `length` > DEPTH is clamped to DEPTH. `base_addr` ≥ DEPTH is replaced by 0.
- Length 0: no beats, no transition to RUN; `done` pulses the cycle after `start`, and `busy` stays 0.
- Read pipeline:
  - Stage A: `bram_addr` register plus valid bit vA.
  - Stage B: BRAM output plus valid bit vB.
  - Output FIFO: 4 entries.
- Issue rule: a new address issues in a cycle iff RUN, issued < length, and FIFO occupancy + vA + vB < 4. Otherwise vA = 0, and `bram_addr` holds its value.
- Address increment: +1 per issue, with DEPTH-1 wrapping to 0.
- FIFO write: on vB, capture `bram_dout`.
- FIFO read: on `m_valid && m_ready`.
- `m_valid` = FIFO not empty. `m_data` = FIFO head, stable while `m_valid && !m_ready`.
- `start` while `busy` is ignored; it does not re-sample `base_addr` or `length`.
- Counters: issued and delivered counters are each ADDR_WIDTH+1 bits. Completion is delivered == length.

## Timing
- Reset values: `busy`=0, `done`=0, `bram_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, FIFO empty, vA=vB=0.
- Reset asserted mid-transfer aborts immediately: FIFO flushed, no `done`.
- Cycle numbering: `start` is sampled in cycle 0.
  - Cycle 1: `busy`=1, `bram_addr`=base.
  - Cycle 2: `bram_dout`=mem[base].
  - Cycle 3: `m_valid`=1 with mem[base]. Start-to-first-beat latency is 3 cycles.
- Throughput: with `m_ready` held high, 1 beat/cycle sustained and no gaps. The last beat is presented in cycle length+2.
- Backpressure: when `m_ready` is low, issue stops once occupancy + in-flight = 4. No word is dropped, because in-flight reads always have a FIFO slot.
- Resume: after `m_ready` rises, the first beat gap is at most 2 cycles, while the refill passes through the BRAM.
- Completion: `done`=1 and `busy`=0 in the cycle after the final handshake. A new `start` is accepted in that same cycle.
- Wrap-around: base=DEPTH-2 and length=4 read addresses DEPTH-2, DEPTH-1, 0, 1, in that order.

## Configuration
- `BRAM_RD_LAST_EN` defined: the `m_last` port exists. It is high with the beat whose delivered index = length-1, and follows the same valid/stability rules as `m_data`.
- Not defined: `m_last` is absent, and no last-tracking logic is built. Downstream logic counts beats itself, or uses `done`.

## Test plan
- Preload mem[i]=i+0x100. Start with base=0, length=8, `m_ready`=1 -> first `m_valid` in cycle 3; beats 0x100..0x107 on consecutive cycles; `done` pulse one cycle after the 8th beat.
- base=DEPTH-2, length=4 -> data mem[DEPTH-2], mem[DEPTH-1], mem[0], mem[1]; with `BRAM_RD_LAST_EN`, `m_last` is high only on mem[1].
- length=16 with random `m_ready` (~50%) -> exactly 16 beats, in order, with no duplicates; `m_data` is stable across every stalled cycle; FIFO never overflows (assertion).
- length=0 -> `done` pulses in cycle 1, `busy` stays 0, no `m_valid`. Then length=DEPTH+5 -> exactly DEPTH beats.
- A second `start` with different base mid-transfer -> ignored; the original sequence completes unchanged.
- `rst_n` dropped after 3 of 10 beats -> all outputs 0 asynchronously. A fresh start with length=2 then delivers exactly 2 correct beats and no stale data.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Streams a contiguous, wrap-around range of BRAM words out as valid/ready beats.
// Optional m_last output is built only when BRAM_RD_LAST_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// RUN   | issuing reads and draining the output FIFO until the final beat
module bram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef BRAM_RD_LAST_EN
  ,
  output logic                  m_last
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state;
  logic [CW-1:0]         len_r;
  logic [CW-1:0]         issued;
  logic [CW-1:0]         delivered;
  logic                  va;
  logic                  vb;
  logic                  done_r;

  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_count;

  logic [CW-1:0]         eff_len;
  logic [ADDR_WIDTH-1:0] eff_base;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [2:0]            in_flight;
  logic                  issue;
  logic                  pop;
  logic                  final_beat;

  always_comb begin
    eff_len = length;
    if (length > DEPTH_C) eff_len = DEPTH_C;
    eff_base = base_addr;
    if ({1'b0, base_addr} >= DEPTH_C) eff_base = '0;
  end

  assign next_addr = (bram_addr == LAST_ADDR) ? '0 : bram_addr + ADDR_WIDTH'(1);

  // Reads already in the pipe are counted so each one is guaranteed a FIFO slot.
  assign in_flight  = fifo_count + {2'b00, va} + {2'b00, vb};
  assign issue      = (state == RUN) && (issued < len_r) && (in_flight < 3'd4);

  assign m_valid    = (fifo_count != 3'd0);
  assign m_data     = fifo_mem[rd_ptr];
  assign pop        = m_valid && m_ready;
  assign final_beat = pop && ((delivered + CW'(1)) == len_r);

  assign busy = (state == RUN);
  assign done = done_r;

`ifdef BRAM_RD_LAST_EN
  assign m_last = m_valid && (delivered == (len_r - CW'(1)));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_r     <= '0;
      issued    <= '0;
      delivered <= '0;
      bram_addr <= '0;
      va        <= 1'b0;
      vb        <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      va     <= 1'b0;
      vb     <= va;
      case (state)
        IDLE: begin
          if (start) begin
            if (eff_len != '0) begin
              // First read issues on the accepting edge to reach a 3-cycle first beat.
              state     <= RUN;
              len_r     <= eff_len;
              bram_addr <= eff_base;
              va        <= 1'b1;
              issued    <= CW'(1);
              delivered <= '0;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            bram_addr <= next_addr;
            va        <= 1'b1;
            issued    <= issued + CW'(1);
          end
          if (pop) begin
            delivered <= delivered + CW'(1);
          end
          if (final_beat) begin
            state  <= IDLE;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (vb) begin
        fifo_mem[wr_ptr] <= bram_dout;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({vb, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, queue-based reference of expected beats.
module tb_bram_stream_reader;
  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int AW    = $clog2(DEPTH);

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   len_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
`ifdef BRAM_RD_LAST_EN
  logic          m_last;
`endif

  logic [DW-1:0] mem [DEPTH];
  int total;
  int passed;

  bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .bram_addr(bram_addr),
    .bram_dout(bram_dout),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready)
`ifdef BRAM_RD_LAST_EN
    ,
    .m_last(m_last)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) bram_dout <= mem[bram_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one start and follows the stream until done; inj_cyc >= 0 pulses a stray start.
  task automatic run_xfer(input int base, input int len, input bit rand_ready,
                          input int inj_cyc, input int inj_base);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data;
    int eff_base, eff_len, cyc, idx;
    bit waiting_done, finished, prev_stall;
    eff_base = (base >= DEPTH) ? 0 : base;
    eff_len  = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < eff_len; i++) exp_q.push_back(mem[(eff_base + i) % DEPTH]);

    start = 1'b1; base_addr = addr_t'(base); length = len_t'(len); m_ready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 1; idx = 0; finished = 0; prev_stall = 0; prev_data = '0;
    waiting_done = (eff_len == 0);
    if (eff_len > 0) begin
      check("busy_cycle1", busy, 1);
      check("addr_cycle1", bram_addr, eff_base);
    end
    while (!finished && cyc < eff_len * 20 + 20) begin
      check("fifo_occ_le4", dut.fifo_count <= 3'd4, 1);
      if (waiting_done) begin
        check("done_pulse", done, 1);
        check("busy_after_done", busy, 0);
        check("valid_after_done", m_valid, 0);
        if (!rand_ready) check("done_cycle", cyc, (eff_len == 0) ? 1 : eff_len + 3);
        finished = 1;
      end else begin
        check("done_early", done, 0);
        if (prev_stall) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
        end
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cyc == inj_cyc) begin
          start = 1'b1; base_addr = addr_t'(inj_base); length = len_t'(5);
        end else begin
          start = 1'b0;
        end
`ifdef BRAM_RD_LAST_EN
        if (m_valid) check("m_last", m_last, idx == eff_len - 1);
`endif
        if (m_valid && m_ready) begin
          check("beat_data", m_data, exp_q[idx]);
          if (!rand_ready) check("beat_cycle", cyc, idx + 3);
          idx++;
          if (idx == eff_len) waiting_done = 1;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
      if (!finished) begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    check("beat_count", idx, eff_len);
    check("xfer_finished", finished, 1);
  endtask

  initial begin
    int nbeats;
    total = 0; passed = 0;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0;
    base_addr = '0; length = '0; m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h100);

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_addr", bram_addr, 0);
`ifdef BRAM_RD_LAST_EN
    check("rst_last", m_last, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_xfer(0, 8, 0, -1, 0);
    run_xfer(DEPTH - 2, 4, 0, -1, 0);
    run_xfer(5, 16, 1, -1, 0);
    run_xfer(7, 0, 0, -1, 0);
    run_xfer(3, DEPTH + 5, 0, -1, 0);
    run_xfer(40, 12, 0, 5, 90);

    // Abort mid-transfer with reset, then confirm a clean restart.
    base_addr = addr_t'(10); length = len_t'(10); start = 1'b1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    nbeats = 0;
    for (int c = 0; c < 20 && nbeats < 3; c++) begin
      if (m_valid && m_ready) nbeats++;
      tick();
    end
    check("pre_reset_beats", nbeats, 3);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", m_valid, 0);
    check("abort_data", m_data, 0);
    check("abort_addr", bram_addr, 0);
`ifdef BRAM_RD_LAST_EN
    check("abort_last", m_last, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_valid", m_valid, 0);
    run_xfer(20, 2, 0, -1, 0);

    for (int r = 0; r < 4; r++) begin
      run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 24)), 1, -1, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
